// File: rtl/ni_resp_arb_pkg.sv
// Shared types and default widths for the B/R response arbiter.
package ni_resp_arb_pkg;

    localparam int DEF_IDWD    = 4;
    localparam int DEF_DATAWD  = 64;
    localparam int DEF_RESPWD  = 2;
    localparam int DEF_TIMEOUT = 255;
    localparam int WDOG_CNTWD  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_B_XFER  = 2'd1,
        ST_R_BURST = 2'd2
    } state_t;

    typedef enum logic {
        CH_B = 1'b0,
        CH_R = 1'b1
    } chan_t;

endpackage

// File: rtl/ni_resp_arb_wdog.sv
// R-gap watchdog: counts idle rvalid cycles inside an R burst, sticky flag at TIMEOUT.
// Latency: flag rises one cycle after the counter reaches TIMEOUT.
// Backpressure: none; a stalled-but-valid beat holds the count without advancing it.
module ni_resp_arb_wdog
    import ni_resp_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_burst,
    input  logic rvalid,
    input  logic r_acc,
    output logic timeout_err
);

    localparam logic [WDOG_CNTWD-1:0] LIMIT = WDOG_CNTWD'(TIMEOUT);

    logic [WDOG_CNTWD-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!in_burst || r_acc) begin
                cnt <= '0;
            end else if (!rvalid && cnt != LIMIT) begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == LIMIT) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_resp_arbiter.sv
// Round-robin B/R response arbiter into one packetizer; R bursts are atomic. Watchdog via NI_RESP_ARB_WDOG_EN.
// Latency: one cycle from source handshake to pkt_valid, one beat per cycle sustained.
// Backpressure: pkt_ready low freezes the output register and drops bready/rready.
module ni_resp_arbiter
    import ni_resp_arb_pkg::*;
#(
    parameter int IDWD    = DEF_IDWD,
    parameter int DATAWD  = DEF_DATAWD,
    parameter int RESPWD  = DEF_RESPWD,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bvalid,
    output logic              bready,
    input  logic [IDWD-1:0]   bid,
    input  logic [RESPWD-1:0] bresp,
    input  logic              rvalid,
    output logic              rready,
    input  logic [IDWD-1:0]   rid,
    input  logic [DATAWD-1:0] rdata,
    input  logic [RESPWD-1:0] rresp,
    input  logic              rlast,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              pkt_is_read,
    output logic [IDWD-1:0]   pkt_id,
    output logic [DATAWD-1:0] pkt_data,
    output logic [RESPWD-1:0] pkt_resp,
    output logic              pkt_first,
    output logic              pkt_last
`ifdef NI_RESP_ARB_WDOG_EN
    ,
    output logic              timeout_err
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("ni_resp_arbiter: TIMEOUT must be within 1..255");
    end

    state_t state;
    chan_t  rr_last;
    logic   run_q;
    logic   out_free;
    logic   grant_b;
    logic   grant_r;
    logic   b_acc;
    logic   r_acc;

    // run_q keeps the readies low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    assign out_free = !pkt_valid || pkt_ready;

    always_comb begin
        grant_b = 1'b0;
        grant_r = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bvalid && (!rvalid || rr_last == CH_R)) grant_b = 1'b1;
                else if (rvalid)                            grant_r = 1'b1;
            end
            ST_B_XFER:  grant_b = 1'b1;
            ST_R_BURST: grant_r = 1'b1;
            default: ;
        endcase
    end

    assign bready = run_q && grant_b && out_free;
    assign rready = run_q && grant_r && out_free;
    assign b_acc  = bready && bvalid;
    assign r_acc  = rready && rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            rr_last <= CH_R;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (b_acc) begin
                        rr_last <= CH_B;
                    end else if (r_acc) begin
                        rr_last <= CH_R;
                        state   <= rlast ? ST_IDLE : ST_R_BURST;
                    end else if (grant_b && run_q) begin
                        // B won but the packetizer is busy: lock the grant.
                        state <= ST_B_XFER;
                    end
                end
                ST_B_XFER: begin
                    if (b_acc) begin
                        rr_last <= CH_B;
                        state   <= ST_IDLE;
                    end
                end
                ST_R_BURST: begin
                    if (r_acc && rlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_valid   <= 1'b0;
            pkt_is_read <= 1'b0;
            pkt_id      <= '0;
            pkt_data    <= '0;
            pkt_resp    <= '0;
            pkt_first   <= 1'b0;
            pkt_last    <= 1'b0;
        end else if (b_acc) begin
            pkt_valid   <= 1'b1;
            pkt_is_read <= 1'b0;
            pkt_id      <= bid;
            pkt_data    <= '0;
            pkt_resp    <= bresp;
            pkt_first   <= 1'b1;
            pkt_last    <= 1'b1;
        end else if (r_acc) begin
            pkt_valid   <= 1'b1;
            pkt_is_read <= 1'b1;
            pkt_id      <= rid;
            pkt_data    <= rdata;
            pkt_resp    <= rresp;
            pkt_first   <= (state == ST_IDLE);
            pkt_last    <= rlast;
        end else if (pkt_ready) begin
            pkt_valid   <= 1'b0;
        end
    end

`ifdef NI_RESP_ARB_WDOG_EN
    ni_resp_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .in_burst    (state == ST_R_BURST),
        .rvalid      (rvalid),
        .r_acc       (r_acc),
        .timeout_err (timeout_err)
    );
`endif

endmodule

// File: doc/ni_resp_arbiter.md
NI_RESP_ARBITER -- requirements
Module: ni_resp_arbiter

Interface
REQ-001 SHALL have parameter IDWD, default 4, AXI ID width.
REQ-002 SHALL have parameter DATAWD, default 64, R data width.
REQ-003 SHALL have parameter RESPWD, default 2, AXI response width.
REQ-004 SHALL have parameter TIMEOUT, default 255, range 1..255, R-gap watchdog limit in cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports are clk and rst.
REQ-006 clk  in  1  noc_clk domain clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 bvalid in 1, bready out 1, bid in IDWD, bresp in RESPWD: AXI B channel from the target.
REQ-009 rvalid in 1, rready out 1, rid in IDWD, rdata in DATAWD, rresp in RESPWD, rlast in 1: AXI R channel from the target.
REQ-010 pkt_valid out 1, pkt_ready in 1: beat handshake to the response packetizer; pkt_ready is the inverse of packetizer stall.
REQ-011 pkt_is_read out 1, pkt_id out IDWD, pkt_data out DATAWD, pkt_resp out RESPWD, pkt_first out 1, pkt_last out 1: registered beat payload.
REQ-012 timeout_err out 1: sticky R-gap watchdog flag. Present only with the macro in REQ-027.

Function
REQ-013 SHALL share one packetizer between B and R. A packet is atomic: one B beat, or one R burst ending at rlast.
REQ-014 FSM states: IDLE, B_XFER, R_BURST.
REQ-015 IDLE:
- bvalid only -> grant B.
- rvalid only -> grant R.
- both -> grant the channel not granted last (rr_last, reset value = R, so B wins first).
REQ-016 Beat acceptance: a beat is accepted when the source is granted, its valid=1, and out_free = !pkt_valid || pkt_ready. bready/rready SHALL be combinational grant && out_free.
REQ-017 B grant: B beat accepted -> output register loaded with is_read=0, first=1, last=1, data=0; FSM returns to IDLE; rr_last=B.
REQ-018 R grant: first accepted R beat -> first=1, rr_last=R.
- If rlast=1 -> IDLE.
- Else -> R_BURST.
REQ-019 R_BURST: each accepted beat has first=0. The beat with rlast=1 -> IDLE. rvalid gaps keep R_BURST, and B SHALL NOT be granted.
REQ-020 Latency: one cycle from source handshake to pkt_valid. Full throughput of one beat per cycle when pkt_ready stays high.
REQ-021 pkt_ready=0 with pkt_valid=1: all pkt_* outputs SHALL hold stable; no beat accepted.
REQ-022 pkt_valid SHALL fall the cycle after a pkt handshake if no new beat was accepted in that handshake cycle.
REQ-023 Grant decision in IDLE and first-beat acceptance SHALL occur in the same cycle (no bubble).

Reset
REQ-024 rst=0 SHALL asynchronously set:
- FSM=IDLE, rr_last=R;
- pkt_valid=0, pkt_is_read=0, pkt_id=0, pkt_data=0, pkt_resp=0, pkt_first=0, pkt_last=0;
- bready=0, rready=0;
- timeout_err=0, watchdog counter=0.
REQ-025 Reset mid-burst SHALL abandon the burst. The partial packet is not completed; the packetizer is reset by the same rst.
REQ-026 Outputs SHALL stay at reset values until the first clk edge after rst deasserts.

Configuration
REQ-027 Macro NI_RESP_ARB_WDOG_EN.
- Defined: an 8-bit counter increments each R_BURST cycle with rvalid=0, clears on any accepted R beat or on leaving R_BURST, and saturates at TIMEOUT. Reaching TIMEOUT sets timeout_err, which stays set until rst. Arbitration is unaffected.
- Undefined: no counter and no timeout_err port.

Structure
REQ-028 Package ni_resp_arb_pkg SHALL hold the FSM state enum (2-bit), the channel-select type (B/R), and the default width constants.
REQ-029 The watchdog SHALL be sub-module ni_resp_arb_wdog, instantiated only under NI_RESP_ARB_WDOG_EN. Arbitration and FSM are inline.

Verification
REQ-030 bvalid=1, bid=3, bresp=2, pkt_ready=1 after reset -> next cycle pkt_valid=1, is_read=0, id=3, resp=2, first=last=1.
REQ-031 bvalid and rvalid both high in IDLE, R burst of 4 beats, rid=5 -> B granted first; R beats follow with first=1 on beat 0 and last=1 on beat 3.
REQ-032 R burst of 8 with rvalid gap of 3 cycles after beat 2, bvalid=1 throughout -> bready stays 0 until the rlast beat is accepted; B granted next.
REQ-033 pkt_ready=0 for 5 cycles mid-burst -> pkt_* stable, rready=0, no beat lost or duplicated; data sequence matches rdata order.
REQ-034 rst pulsed low during beat 2 of a 4-beat burst -> all outputs at reset values immediately; FSM=IDLE; next bvalid granted first.
REQ-035 With NI_RESP_ARB_WDOG_EN and TIMEOUT=4, rvalid=0 for 4 cycles in R_BURST -> timeout_err=1 and stays 1 after the burst completes.
